// File: rtl/tile_mm_sequencer.sv
// rtl/tile_mm_sequencer.sv - loop controller for tiled C = A * B: walks i/l/r tiles and drives phase handshakes
module tile_mm_sequencer #(
    parameter int M     = 4,
    parameter int P     = 6,
    parameter int N     = 4,
    parameter int TJ    = 2,
    parameter int TK    = 4,
    parameter int IDX_W = 10
) (
    input  logic             clk,
    input  logic             rst,
    input  logic             start,
    output logic             busy,
    output logic             done,
    output logic [IDX_W-1:0] tile_i,
    output logic [IDX_W-1:0] tile_l,
    output logic [IDX_W-1:0] tile_r,
    output logic [IDX_W-1:0] ext_i,
    output logic [IDX_W-1:0] ext_l,
    output logic [IDX_W-1:0] ext_r,
    output logic             lda_go,
    input  logic             lda_ack,
    output logic             ldb_go,
    input  logic             ldb_ack,
    output logic             mul_go,
    input  logic             mul_ack,
    output logic             acc_go,
    output logic             acc_first,
    input  logic             acc_ack,
    output logic             wb_go,
    input  logic             wb_ack
);

    typedef enum logic [2:0] {IDLE, FETCH_A, FETCH_B, MUL, ACC, WB, FIN} state_t;
    state_t state;

    localparam logic [IDX_W:0] M_W  = (IDX_W+1)'(M);
    localparam logic [IDX_W:0] N_W  = (IDX_W+1)'(N);
    localparam logic [IDX_W:0] P_W  = (IDX_W+1)'(P);
    localparam logic [IDX_W:0] TJ_W = (IDX_W+1)'(TJ);
    localparam logic [IDX_W:0] TK_W = (IDX_W+1)'(TK);

    // One extra bit so base+step and dim-base never wrap near the index limit.
    function automatic logic [IDX_W-1:0] extent(input logic [IDX_W:0] dim,
                                                 input logic [IDX_W:0] base,
                                                 input logic [IDX_W:0] step);
        logic [IDX_W:0] rem;
        rem = dim - base;
        return (rem < step) ? rem[IDX_W-1:0] : step[IDX_W-1:0];
    endfunction

    logic [IDX_W:0] i_nx, l_nx, r_nx;
    assign i_nx = {1'b0, tile_i} + TJ_W;
    assign l_nx = {1'b0, tile_l} + TK_W;
    assign r_nx = {1'b0, tile_r} + TK_W;

    // A *_go register is high only in the first cycle of its state, so !go marks
    // the cycles where the matching ack may be honoured.
    always_ff @(posedge clk or posedge rst) begin
        if (rst) begin
            state     <= IDLE;
            busy      <= 1'b0;
            done      <= 1'b0;
            tile_i    <= '0;
            tile_l    <= '0;
            tile_r    <= '0;
            ext_i     <= '0;
            ext_l     <= '0;
            ext_r     <= '0;
            lda_go    <= 1'b0;
            ldb_go    <= 1'b0;
            mul_go    <= 1'b0;
            acc_go    <= 1'b0;
            acc_first <= 1'b0;
            wb_go     <= 1'b0;
        end else begin
            lda_go    <= 1'b0;
            ldb_go    <= 1'b0;
            mul_go    <= 1'b0;
            acc_go    <= 1'b0;
            acc_first <= 1'b0;
            wb_go     <= 1'b0;
            done      <= 1'b0;
            case (state)
                IDLE: if (start) begin
                    tile_i <= '0;
                    tile_l <= '0;
                    tile_r <= '0;
                    ext_i  <= extent(M_W, '0, TJ_W);
                    ext_l  <= extent(N_W, '0, TK_W);
                    ext_r  <= extent(P_W, '0, TK_W);
                    busy   <= 1'b1;
                    lda_go <= 1'b1;
                    state  <= FETCH_A;
                end
                FETCH_A: if (!lda_go && lda_ack) begin
                    ldb_go <= 1'b1;
                    state  <= FETCH_B;
                end
                FETCH_B: if (!ldb_go && ldb_ack) begin
                    mul_go <= 1'b1;
                    state  <= MUL;
                end
                MUL: if (!mul_go && mul_ack) begin
                    acc_go    <= 1'b1;
                    acc_first <= (tile_r == '0);
                    state     <= ACC;
                end
                ACC: if (!acc_go && acc_ack) begin
                    if (r_nx < P_W) begin
                        tile_r <= r_nx[IDX_W-1:0];
                        ext_r  <= extent(P_W, r_nx, TK_W);
                        lda_go <= 1'b1;
                        state  <= FETCH_A;
                    end else begin
                        wb_go <= 1'b1;
                        state <= WB;
                    end
                end
                WB: if (!wb_go && wb_ack) begin
                    tile_r <= '0;
                    ext_r  <= extent(P_W, '0, TK_W);
                    if (l_nx < N_W) begin
                        tile_l <= l_nx[IDX_W-1:0];
                        ext_l  <= extent(N_W, l_nx, TK_W);
                        lda_go <= 1'b1;
                        state  <= FETCH_A;
                    end else begin
                        tile_l <= '0;
                        ext_l  <= extent(N_W, '0, TK_W);
                        if (i_nx < M_W) begin
                            tile_i <= i_nx[IDX_W-1:0];
                            ext_i  <= extent(M_W, i_nx, TJ_W);
                            lda_go <= 1'b1;
                            state  <= FETCH_A;
                        end else begin
                            busy  <= 1'b0;
                            done  <= 1'b1;
                            state <= FIN;
                        end
                    end
                end
                FIN:     state <= IDLE;
                default: state <= IDLE;
            endcase
        end
    end

endmodule

// File: tb/tb_tile_mm_sequencer.sv
// tb/tb_tile_mm_sequencer.sv - scoreboard bench: loop-nest reference model vs two sequencer configurations
module tb_tile_mm_sequencer;

    localparam int IW = 10;
    localparam int TJ = 2;
    localparam int TK = 4;

    typedef struct packed {
        logic [2:0]    kind;   // 0 A, 1 B, 2 MUL, 3 ACC, 4 WB, 5 DONE
        logic [IW-1:0] ti, tl, tr, ei, el, er;
        logic          af;
    } ev_t;

    logic          clk = 1'b0;
    logic          rst;
    logic          start [2];
    logic [4:0]    ack   [2];
    wire  [4:0]    go    [2];
    wire           busy  [2];
    wire           done  [2];
    wire           af    [2];
    wire  [IW-1:0] ti [2], tl [2], tr [2], ei [2], el [2], er [2];

    ev_t exp_q [2][$];
    int  acc_cnt [2];
    int  wb_cnt  [2];
    int  errors = 0;
    int  checks = 0;

    always #5 clk = ~clk;

    for (genvar u = 0; u < 2; u++) begin : g_dut
        tile_mm_sequencer #(
            .M(u == 0 ? 4 : 5), .P(6), .N(u == 0 ? 4 : 6), .TJ(TJ), .TK(TK), .IDX_W(IW)
        ) dut (
            .clk(clk), .rst(rst), .start(start[u]), .busy(busy[u]), .done(done[u]),
            .tile_i(ti[u]), .tile_l(tl[u]), .tile_r(tr[u]),
            .ext_i(ei[u]), .ext_l(el[u]), .ext_r(er[u]),
            .lda_go(go[u][0]), .lda_ack(ack[u][0]),
            .ldb_go(go[u][1]), .ldb_ack(ack[u][1]),
            .mul_go(go[u][2]), .mul_ack(ack[u][2]),
            .acc_go(go[u][3]), .acc_first(af[u]), .acc_ack(ack[u][3]),
            .wb_go(go[u][4]), .wb_ack(ack[u][4])
        );
    end

    function automatic int dim_m(input int u); return (u == 0) ? 4 : 5; endfunction
    function automatic int dim_n(input int u); return (u == 0) ? 4 : 6; endfunction
    function automatic int dim_p(input int u); return 6; endfunction
    function automatic int imin(input int a, input int b); return (a < b) ? a : b; endfunction
    function automatic int cdiv(input int a, input int b); return (a + b - 1) / b; endfunction

    task automatic chk(input string name, input longint act, input longint exp);
        checks++;
        if (act !== exp) begin
            errors++;
            $display("FAIL %s: got %0d expected %0d", name, act, exp);
        end
    endtask

    function automatic ev_t mk(input int k, input int i, input int l, input int r,
                               input int xi, input int xl, input int xr, input bit f);
        ev_t e;
        e.kind = 3'(k);
        e.ti = IW'(i); e.tl = IW'(l); e.tr = IW'(r);
        e.ei = IW'(xi); e.el = IW'(xl); e.er = IW'(xr);
        e.af = f;
        return e;
    endfunction

    // Expected event stream of a whole job, straight from the i/l/r loop nest.
    task automatic push_job(input int u);
        int m = dim_m(u), n = dim_n(u), p = dim_p(u);
        int last_r;
        for (int i = 0; i < m; i += TJ)
            for (int l = 0; l < n; l += TK) begin
                last_r = 0;
                for (int r = 0; r < p; r += TK) begin
                    for (int k = 0; k < 4; k++)
                        exp_q[u].push_back(mk(k, i, l, r, imin(TJ, m - i), imin(TK, n - l),
                                              imin(TK, p - r), (k == 3) && (r == 0)));
                    last_r = r;
                end
                exp_q[u].push_back(mk(4, i, l, last_r, imin(TJ, m - i), imin(TK, n - l),
                                      imin(TK, p - last_r), 1'b0));
            end
        exp_q[u].push_back(mk(5, 0, 0, 0, 0, 0, 0, 1'b0));
    endtask

    task automatic monitor(input int u);
        ev_t a, e;
        forever begin
            @(negedge clk);
            if (rst || (go[u] == 5'd0 && !done[u])) continue;
            a = mk(0, 0, 0, 0, 0, 0, 0, af[u]);
            if (done[u]) a.kind = 3'd5;
            else begin
                for (int k = 4; k >= 0; k--) if (go[u][k]) a.kind = 3'(k);
                a.ti = ti[u]; a.tl = tl[u]; a.tr = tr[u];
                a.ei = ei[u]; a.el = el[u]; a.er = er[u];
            end
            if (go[u][3]) acc_cnt[u]++;
            if (go[u][4]) wb_cnt[u]++;
            checks++;
            if (exp_q[u].size() == 0) begin
                errors++;
                $display("FAIL unexpected_event u=%0d: got %h expected none", u, a);
            end else begin
                e = exp_q[u].pop_front();
                if (a !== e || $countones({go[u], done[u]}) != 1) begin
                    errors++;
                    $display("FAIL event u=%0d: got %h (go=%b done=%b) expected %h", u, a, go[u], done[u], e);
                end
            end
            chk($sformatf("busy_at_event u=%0d", u), busy[u], !done[u]);
        end
    endtask

    // Acks arrive 1-3 cycles after go; also throws in ignored acks in the go cycle and stray acks of other phases.
    task automatic responder(input int u);
        logic [4:0] g;
        int d;
        ack[u] = '0;
        forever begin
            @(negedge clk);
            ack[u] = '0;
            if (rst || go[u] == 5'd0) continue;
            g = go[u];
            if ($urandom_range(0, 2) == 0) ack[u] = g;
            d = $urandom_range(1, 3);
            for (int k = 0; k < d - 1; k++) begin
                @(negedge clk);
                ack[u] = 5'($urandom) & ~g;
            end
            @(negedge clk);
            ack[u] = g;
        end
    endtask

    task automatic run_job(input int u, input bit harass);
        bit seen = 0;
        acc_cnt[u] = 0;
        wb_cnt[u] = 0;
        push_job(u);
        @(negedge clk);
        start[u] = 1'b1;
        @(negedge clk);
        for (int c = 0; c < 3000; c++) begin
            if (done[u]) begin
                seen = 1;
                start[u] = harass;
                break;
            end
            start[u] = harass && ($urandom_range(0, 3) == 0);
            @(negedge clk);
        end
        @(negedge clk);
        start[u] = 1'b0;
        chk($sformatf("done_seen u=%0d", u), seen, 1);
        repeat (4) @(negedge clk);
        chk($sformatf("idle_after_job u=%0d", u), busy[u], 0);
        chk($sformatf("queue_drained u=%0d", u), exp_q[u].size(), 0);
        chk($sformatf("acc_count u=%0d", u), acc_cnt[u],
            cdiv(dim_m(u), TJ) * cdiv(dim_n(u), TK) * cdiv(dim_p(u), TK));
        chk($sformatf("wb_count u=%0d", u), wb_cnt[u], cdiv(dim_m(u), TJ) * cdiv(dim_n(u), TK));
    endtask

    task automatic check_zero(input int u, input string name);
        chk({name, "_ctrl"}, {busy[u], done[u], go[u], af[u]}, 0);
        chk({name, "_idx"}, ti[u] | tl[u] | tr[u] | ei[u] | el[u] | er[u], 0);
    endtask

    initial fork
        monitor(0);
        monitor(1);
        responder(0);
        responder(1);
    join

    initial begin
        bit hit = 0;
        rst = 1'b1;
        start[0] = 1'b0;
        start[1] = 1'b0;
        repeat (3) @(negedge clk);
        check_zero(0, "reset0");
        check_zero(1, "reset1");
        rst = 1'b0;

        fork
            run_job(0, 1'b0);
            run_job(1, 1'b0);
        join
        fork
            run_job(0, 1'b1);
            run_job(1, 1'b1);
        join
        fork
            run_job(0, 1'b0);
            run_job(1, 1'b0);
        join

        push_job(0);
        @(negedge clk);
        start[0] = 1'b1;
        @(negedge clk);
        start[0] = 1'b0;
        for (int c = 0; c < 200; c++) begin
            if (go[0][3]) begin
                hit = 1;
                break;
            end
            @(negedge clk);
        end
        chk("reach_acc", hit, 1);
        #2 rst = 1'b1;
        #1;
        check_zero(0, "rst_mid0");
        check_zero(1, "rst_mid1");
        exp_q[0].delete();
        exp_q[1].delete();
        repeat (2) @(negedge clk);
        rst = 1'b0;
        repeat (6) @(negedge clk);
        chk("no_done_after_rst", busy[0] | done[0], 0);

        fork
            run_job(0, 1'b0);
            run_job(1, 1'b0);
        join

        $display("Result: errors=%0d of %0d checks", errors, checks);
        $finish;
    end

endmodule
